// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel stream in, 3x3 window out; WIN_IDX_EN adds window coordinates
interface sobel_window_gen_if;
    logic        frame_start;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic [71:0] Image;
    logic        Start;
    logic        busy;
    logic        frame_done;
`ifdef WIN_IDX_EN
    logic [15:0] win_row;
    logic [15:0] win_col;
`endif

    modport master (
        output frame_start, pix_valid, pix_in,
`ifdef WIN_IDX_EN
        input  win_row, win_col,
`endif
        input  Image, Start, busy, frame_done
    );

    modport slave (
        input  frame_start, pix_valid, pix_in,
`ifdef WIN_IDX_EN
        output win_row, win_col,
`endif
        output Image, Start, busy, frame_done
    );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - two-line-buffer 3x3 window generator for the convolution stage; WIN_IDX_EN adds win_row/win_col
module sobel_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    sobel_window_gen_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    // Two newest columns of each window row; the third column is the incoming one.
    logic [7:0]    hist_q [3][2];

    logic          accept, last_col, last_row, emit;
    logic [CW-1:0] rd_col;
    logic [7:0]    up1, up2;
    logic [71:0]   win_next;

    assign accept   = bus.pix_valid && (state_q != IDLE);
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    // A pixel coinciding with an abort restarts at column 0.
    assign rd_col   = bus.frame_start ? '0 : col_q;
    assign up1      = lb1[rd_col];
    assign up2      = lb2[rd_col];
    assign emit     = accept && !bus.frame_start && (state_q == RUN) && (col_q >= CW'(2));
    assign win_next = {hist_q[0][0], hist_q[0][1], up2,
                       hist_q[1][0], hist_q[1][1], up1,
                       hist_q[2][0], hist_q[2][1], bus.pix_in};
    assign bus.busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.frame_start) state_d = FILL;
            FILL: begin
                if (bus.frame_start)                           state_d = FILL;
                else if (accept && last_col && row_q == RW'(1)) state_d = RUN;
            end
            RUN: begin
                if (bus.frame_start)                    state_d = FILL;
                else if (accept && last_col && last_row) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (bus.frame_start) begin
            row_q <= '0;
            col_q <= accept ? CW'(1) : '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Read-before-write: row r-1 moves down to r-2 as the new pixel lands in r-1.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[rd_col] <= bus.pix_in;
            lb2[rd_col] <= up1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                hist_q[i][0] <= '0;
                hist_q[i][1] <= '0;
            end
            bus.Image      <= '0;
            bus.Start      <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 3; i++) hist_q[i][0] <= hist_q[i][1];
                hist_q[0][1] <= up2;
                hist_q[1][1] <= up1;
                hist_q[2][1] <= bus.pix_in;
            end
            if (emit) bus.Image <= win_next;
            bus.Start      <= emit;
            bus.frame_done <= emit && last_col && last_row;
        end
    end

`ifdef WIN_IDX_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bus.win_row <= '0;
            bus.win_col <= '0;
        end else if (emit) begin
            bus.win_row <= 16'(row_q - RW'(2));
            bus.win_col <= 16'(col_q - CW'(2));
        end
    end
`endif
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench: 4x4 instance for the directed scenarios, 32x32 for full-size frames
module tb_sobel_window_gen;
    typedef struct {
        logic [71:0] img;
        bit          done;
        int          r;
        int          c;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_start_b = 0;
    int   n_done_b = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  pm [2][32][32];
    bit          act [2];
    int          mr [2];
    int          mc [2];
    logic [71:0] last_img [2];

    sobel_window_gen_if ifa();
    sobel_window_gen_if ifb();

    sobel_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa.slave));
    sobel_window_gen dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: pixels land in a frame array by raster position; each position
    // with a full neighbourhood yields the 3x3 block read straight from that array.
    task automatic step(input int d, input bit fs, input bit pv, input logic [7:0] px);
        bit   was;
        int   r, c, w;
        exp_t e;
        w   = (d == 1) ? 32 : 4;
        was = act[d];
        if (fs) begin
            act[d] = 1;
            mr[d]  = 0;
            mc[d]  = 0;
        end
        if (pv && was) begin
            r = mr[d];
            c = mc[d];
            pm[d][r][c] = px;
            if (r >= 2 && c >= 2) begin
                e.img  = {pm[d][r-2][c-2], pm[d][r-2][c-1], pm[d][r-2][c],
                          pm[d][r-1][c-2], pm[d][r-1][c-1], pm[d][r-1][c],
                          pm[d][r][c-2],   pm[d][r][c-1],   pm[d][r][c]};
                e.done = (r == w - 1) && (c == w - 1);
                e.r    = r - 2;
                e.c    = c - 2;
                e.cyc  = cyc + 1;
                if (d == 0) qa.push_back(e);
                else        qb.push_back(e);
            end
            if (c == w - 1) begin
                mc[d] = 0;
                mr[d] = r + 1;
            end else begin
                mc[d] = c + 1;
            end
            if (r == w - 1 && c == w - 1) begin
                act[d] = 0;
                mr[d]  = 0;
            end
        end
        ifa.frame_start = (d == 0) && fs;
        ifa.pix_valid   = (d == 0) && pv;
        ifa.pix_in      = px;
        ifb.frame_start = (d == 1) && fs;
        ifb.pix_valid   = (d == 1) && pv;
        ifb.pix_in      = px;
        @(posedge clk);
        #1;
        chk("busy", 72'((d == 1) ? ifb.busy : ifa.busy), 72'(act[d]));
    endtask

    task automatic mon(input int d, input logic rst, input logic st, input logic fd, input logic [71:0] im);
        exp_t e;
        bit   have;
        have = 0;
        if (rst) begin
            last_img[d] = '0;
            return;
        end
        if (d == 0 && qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            have = 1;
        end
        if (d == 1 && qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            have = 1;
        end
        if (have) begin
            chk("window_cycle", 72'(cyc), 72'(e.cyc));
            chk("start", 72'(st), 72'(1));
            chk("frame_done", 72'(fd), 72'(e.done));
            chk("image", im, e.img);
`ifdef WIN_IDX_EN
            chk("win_row", 72'((d == 1) ? ifb.win_row : ifa.win_row), 72'(e.r));
            chk("win_col", 72'((d == 1) ? ifb.win_col : ifa.win_col), 72'(e.c));
`endif
            last_img[d] = e.img;
        end else begin
            chk("start_idle", 72'(st), 72'(0));
            chk("frame_done_idle", 72'(fd), 72'(0));
            chk("image_hold", im, last_img[d]);
        end
        if (d == 1 && st) n_start_b++;
        if (d == 1 && fd) n_done_b++;
    endtask

    always @(negedge clk) begin
        mon(0, rst_a, ifa.Start, ifa.frame_done, ifa.Image);
        mon(1, rst_b, ifb.Start, ifb.frame_done, ifb.Image);
    end

    task automatic basic_frame(input logic [7:0] base);
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 0, 1, base + 8'(i));
        repeat (2) step(0, 0, 0, 8'h00);
    endtask

    initial begin
        rst_a = 1; rst_b = 1;
        ifa.frame_start = 0; ifa.pix_valid = 0; ifa.pix_in = '0;
        ifb.frame_start = 0; ifb.pix_valid = 0; ifb.pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_image", ifa.Image, 72'(0));
        chk("reset_start", 72'(ifa.Start), 72'(0));
        chk("reset_busy", 72'(ifa.busy), 72'(0));
        chk("reset_frame_done", 72'(ifa.frame_done), 72'(0));
`ifdef WIN_IDX_EN
        chk("reset_win_row", 72'(ifa.win_row), 72'(0));
        chk("reset_win_col", 72'(ifa.win_col), 72'(0));
`endif
        rst_a = 0; rst_b = 0;

        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom));

        basic_frame(8'h00);

        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'(i));
            step(0, 0, 0, 8'($urandom));
        end
        repeat (2) step(0, 0, 0, 8'h00);

        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 8'($urandom_range(0, 63)));
        step(0, 1, 1, 8'h40);
        for (int i = 1; i < 16; i++) step(0, 0, 1, 8'h40 + 8'(i));
        repeat (2) step(0, 0, 0, 8'h00);

        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 8'($urandom));
        rst_a = 1;
        #1;
        chk("midreset_image", ifa.Image, 72'(0));
        chk("midreset_start", 72'(ifa.Start), 72'(0));
        chk("midreset_busy", 72'(ifa.busy), 72'(0));
        qa.delete();
        act[0] = 0; mr[0] = 0; mc[0] = 0;
        @(posedge clk);
        #1;
        rst_a = 0;
        basic_frame(8'h00);

        for (int f = 0; f < 2; f++) begin
            step(0, 1, 0, 8'h00);
            for (int k = 0; k < 200 && act[0]; k++)
                step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
            repeat (2) step(0, 0, 0, 8'h00);
        end

        step(1, 1, 0, 8'h00);
        for (int i = 0; i < 1024; i++) step(1, 0, 1, 8'($urandom));
        repeat (3) step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'($urandom));
        repeat (2) step(1, 0, 0, 8'h00);

        chk("full_frame_starts", 72'(n_start_b), 72'(900));
        chk("full_frame_done_count", 72'(n_done_b), 72'(1));
        chk("pending_a", 72'(qa.size()), 72'(0));
        chk("pending_b", 72'(qb.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Upstream feeder for the 3x3 convolution stage. Accepts a raster-order 8-bit pixel stream and buffers two image lines. For every position where a full 3x3 neighbourhood exists, presents the window as a packed 72-bit `Image` word with a one-cycle `Start` pulse, which is the exact input format of the convolution stage. Only valid windows are produced (no padding): (IMG_W-2)*(IMG_H-2) windows per frame.

## Interface
- `IMG_W`, default 32: pixels per line (≥3).
- `IMG_H`, default 32: lines per frame (≥3).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-high (asserted = 1; the name is kept for codebase consistency).
- `frame_start` input 1: one-cycle pulse that begins a frame.
- `pix_valid` input 1: `pix_in` is valid this cycle.
- `pix_in` input 8: unsigned pixel.
- `Image` output 72: registered window, packed as follows:
  - [71:64]=(r-2,c-2), [63:56]=(r-2,c-1), [55:48]=(r-2,c)
  - [47:40]=(r-1,c-2), [39:32]=(r-1,c-1), [31:24]=(r-1,c)
  - [23:16]=(r,c-2), [15:8]=(r,c-1), [7:0]=(r,c)
- `Start` output 1: one-cycle pulse; `Image` holds a new window.
- `busy` output 1: high in FILL/RUN.
- `frame_done` output 1: one-cycle pulse coincident with the last window's `Start`.

## Operation
- Storage:
  - Two line buffers of IMG_W×8 bits (rows r-1 and r-2).
  - A 3x3 window register, shifted left one column per accepted pixel.
  - Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1), widths `$clog2` of the parameter.
- FSM states: IDLE, FILL, RUN.
  - IDLE: `pix_valid` is ignored. `frame_start` → FILL, and `col`/`row` are cleared.
  - FILL (row < 2): accepted pixels go into the line buffers only; no `Start`. At the end of line 1 → RUN.
  - RUN (row ≥ 2): an accepted pixel with col ≥ 2 produces a window. The last pixel (IMG_H-1, IMG_W-1) → IDLE and pulses `frame_done`.
- Accepted pixel = `pix_valid`=1 in FILL or RUN.
  - `col` increments on each accepted pixel and wraps to 0 at IMG_W-1, which increments `row`.
  - No accept → all state holds.
- Line buffers are read at `col` and written at `col` in the same accept cycle (read-before-write). Buffer row r-1 shifts into row r-2 on the same access.
- `frame_start` in FILL/RUN aborts the frame:
  - counters are cleared and the FSM goes to FILL;
  - stale line-buffer contents are never emitted, because FILL refills both lines before any `Start`.
  - A `pix_valid` in the same cycle as `frame_start` is accepted as pixel (0,0).
- Pixels arriving after `frame_done` while in IDLE are dropped.
- No backpressure: the downstream stage accepts one window per cycle.

## Timing
- Reset values: `Image`=0, `Start`=0, `busy`=0, `frame_done`=0, FSM=IDLE, counters=0. Line-buffer contents are don't-care.
- Latency: pixel (r,c) with r≥2, c≥2 accepted in cycle t → `Start`=1 and its window on `Image` in cycle t+1.
- Throughput: one window per cycle with back-to-back `pix_valid`.
- `Image` holds its value between `Start` pulses. `Start` is never high two cycles in a row unless pixels are accepted in consecutive cycles.
- Gaps in `pix_valid` insert gaps in `Start` only; the data is unaffected.
- `busy` rises the cycle after `frame_start` and falls the cycle after the last pixel is accepted.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). Any in-flight `Start` is lost.

## Configuration
- `WIN_IDX_EN`
  - Defined: adds outputs `win_row` and `win_col`, each 16 bits. They are registered with `Image` and give the window's top-left coordinate (r-2, c-2). Reset value 0.
  - Undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- **Basic 4x4 frame.** IMG_W=IMG_H=4, `frame_start`, then pixels 0x00..0x0F on consecutive cycles → exactly 4 `Start` pulses.
  - First window: `Image`=72'h00_01_02_04_05_06_08_09_0A.
  - Last window: 72'h05_06_07_09_0A_0B_0D_0E_0F, with `frame_done` on the same cycle.
- **Valid gaps.** Same frame with `pix_valid` toggling every other cycle → identical 4 windows, `Start` one cycle after each qualifying accept, `Image` stable in between.
- **Abort and restart.** `frame_start` after 9 pixels, then a full fresh frame of pixel value = index + 0x40 → 4 windows, the first being 72'h40_41_42_44_45_46_48_49_4A; no window contains a value below 0x40.
- **Reset mid-frame.** `rst_n`=1 during row 2 → `Image`=0, `Start`=0, `busy`=0 that cycle. After release, a new frame behaves exactly as in the basic 4x4 frame test.
- **Default size and index outputs.** Default 32x32, back-to-back pixels → 900 `Start` pulses and 1 `frame_done`. With `WIN_IDX_EN`, the last window reports `win_row`=29, `win_col`=29.
- **IDLE pixels ignored.** Pixels with no preceding `frame_start` → no `Start`, `busy`=0.
